vehicle_sensor_conditioner: RTL

- Upstream stage of the highway/farm-road traffic controller. Turns the raw, asynchronous farm-road vehicle-loop detector into the clean, latched car-waiting request `cin` that the controller consumes.
- Synchronises, debounces and dwell-qualifies the detector, then holds the request until the controller serves the farm road.
- Also provides a saturating vehicle count and a stuck-sensor fault flag for status.

---
 rtl/vehicle_sensor_conditioner_pkg.sv | 39 +++
 rtl/vehicle_sensor_conditioner_if.sv | 35 +++
 rtl/vehicle_sensor_conditioner_sync_debounce.sv | 58 +++++
 rtl/vehicle_sensor_conditioner.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vehicle_sensor_conditioner_pkg.sv
// ============================================================================
// vehicle_sensor_conditioner_pkg
//   Shared traffic types and default timing for the highway/farm controller.
//   Rev 1.0
// ============================================================================
`default_nettype none

package vehicle_sensor_conditioner_pkg;

  localparam int DEBOUNCE_DEF     = 4;
  localparam int DWELL_DEF        = 8;
  localparam int STUCK_CYCLES_DEF = 64;
  localparam int COUNT_W          = 8;

  // Farm-road request sequencing
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_REQUEST = 2'd2,
    ST_SERVED  = 2'd3
  } veh_state_e;

  // Highway/farm light sequencing used by the downstream controller
  typedef enum logic [1:0] {
    CTRL_HWY_GREEN   = 2'd0,
    CTRL_HWY_YELLOW  = 2'd1,
    CTRL_FARM_GREEN  = 2'd2,
    CTRL_FARM_YELLOW = 2'd3
  } ctrl_state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    logic [COUNT_W-1:0] r;
    r = (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vehicle_sensor_conditioner_if.sv
// ============================================================================
// vehicle_sensor_conditioner_if
//   Detector/controller signal bundle between loop conditioner and controller.
//   Rev 1.0
// ============================================================================
`default_nettype none

interface vehicle_sensor_conditioner_if;
  import vehicle_sensor_conditioner_pkg::*;

  logic               det_raw;
  logic               serve;
  logic               cin;
  logic [COUNT_W-1:0] car_count;
  logic               fault;

  modport master (
    output det_raw,
    output serve,
    input  cin,
    input  car_count,
    input  fault
  );

  modport slave (
    input  det_raw,
    input  serve,
    output cin,
    output car_count,
    output fault
  );

endinterface

`default_nettype wire

// File: rtl/vehicle_sensor_conditioner_sync_debounce.sv
// ============================================================================
// vehicle_sensor_conditioner_sync_debounce
//   Two-flop synchroniser followed by a consecutive-cycle debounce filter.
//   Rev 1.0
// ============================================================================
`default_nettype none

module vehicle_sensor_conditioner_sync_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  det_raw_i,
  output logic det_stable_o
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (s2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      s1_q      <= det_raw_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign det_stable_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/vehicle_sensor_conditioner.sv
// ============================================================================
// vehicle_sensor_conditioner
//   Turns the raw farm-road loop detector into a latched car-waiting request.
//   Rev 1.0
// ============================================================================
`default_nettype none

module vehicle_sensor_conditioner
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int DWELL        = DWELL_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input wire clk,
  input wire reset,
  vehicle_sensor_conditioner_if.slave bus
);

  localparam int DW_W  = $clog2(DWELL + 1);
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0]  DW_ONE  = DW_W'(1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);
  localparam logic [STK_W-1:0] STK_ONE = STK_W'(1);

  logic               det_stable;
  logic               det_prev_q;
  logic [COUNT_W-1:0] car_count_q;
  logic [COUNT_W-1:0] car_count_d;
  logic [STK_W-1:0]   stuck_cnt_q;
  logic [STK_W-1:0]   stuck_cnt_d;
  logic               fault_q;
  logic               fault_d;
  veh_state_e         state_q;
  veh_state_e         state_d;
  logic [DW_W-1:0]    dwell_cnt_q;
  logic [DW_W-1:0]    dwell_cnt_d;
  logic               cin_w;

  vehicle_sensor_conditioner_sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sync_debounce (
    .clk          (clk),
    .rst_n        (reset),
    .det_raw_i    (bus.det_raw),
    .det_stable_o (det_stable)
  );

  // Vehicle count and stuck-sensor supervision
  always_comb begin
    car_count_d = car_count_q;
    if (det_stable && !det_prev_q) begin
      car_count_d = sat_inc(car_count_q);
    end
    stuck_cnt_d = '0;
    fault_d     = 1'b0;
    if (det_stable) begin
      stuck_cnt_d = (stuck_cnt_q == STK_MAX) ? stuck_cnt_q : stuck_cnt_q + STK_ONE;
      fault_d     = (stuck_cnt_d == STK_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_prev_q  <= 1'b0;
      car_count_q <= '0;
      stuck_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      det_prev_q  <= det_stable;
      car_count_q <= car_count_d;
      stuck_cnt_q <= stuck_cnt_d;
      fault_q     <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  // serve is only acted on in REQUEST and SERVED; elsewhere it is ignored
  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (det_stable) begin
          state_d     = ST_ARMING;
          dwell_cnt_d = '0;
        end
      end
      ST_ARMING: begin
        if (!det_stable) begin
          state_d = ST_IDLE;
        end else if (dwell_cnt_q == DW_LAST) begin
          state_d = ST_REQUEST;
        end else begin
          dwell_cnt_d = dwell_cnt_q + DW_ONE;
        end
      end
      ST_REQUEST: begin
        if (bus.serve) begin
          state_d = ST_SERVED;
        end
      end
      ST_SERVED: begin
        if (!bus.serve) begin
          if (det_stable) begin
            state_d     = ST_ARMING;
            dwell_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cin_w = (state_q == ST_REQUEST);
  end

  assign bus.cin       = cin_w;
  assign bus.car_count = car_count_q;
  assign bus.fault     = fault_q;

endmodule

`default_nettype wire
